instr_prefetch_buf: RTL
=======================

INSTR_PREFETCH_BUF -- requirements
Module: instr_prefetch_buf

Interface
REQ-001 SHALL have parameter DEPTH, default 4, meaning buffer entries (power of two, 2..16).
REQ-002 SHALL have parameter ADDR_W, default 32, meaning fetch address width.
REQ-003 SHALL have parameter INSTR_W, default 32, meaning instruction word width.
REQ-004 SHALL have parameter RESET_PC, default 32'h0000_0000, meaning PC after reset or JTAG reset.
REQ-005 SHALL have port clk_i, input, 1, meaning the single clock; all state on rising edge.
REQ-006 SHALL have port rst_i, input, 1, meaning reset, asynchronous and active-high.
REQ-007 SHALL have port fetch_req_o, output, 1, meaning fetch request to the instruction bus.
REQ-008 SHALL have port fetch_addr_o, output, ADDR_W, meaning fetch address, word aligned.
REQ-009 SHALL have port fetch_ready_i, input, 1, meaning bus accepted the request and fetch_data_i is valid this cycle.
REQ-010 SHALL have port fetch_data_i, input, INSTR_W, meaning fetched instruction.
REQ-011 SHALL have port jump_flag_i, input, 1, meaning redirect (branch, jump, trap).
REQ-012 SHALL have port jump_addr_i, input, ADDR_W, meaning redirect target.
REQ-013 SHALL have port jtag_reset_flag_i, input, 1, meaning restart at RESET_PC.
REQ-014 SHALL have port hold_i, input, 1, meaning suppress new fetch requests.
REQ-015 SHALL have port instr_valid_o, output, 1, meaning instr_o/pc_o/pc_next_o are valid.
REQ-016 SHALL have port instr_ready_i, input, 1, meaning decode consumes the head entry.
REQ-017 SHALL have port instr_o, output, INSTR_W, meaning head instruction.
REQ-018 SHALL have port pc_o, output, ADDR_W, meaning address of instr_o.
REQ-019 SHALL have port pc_next_o, output, ADDR_W, meaning pc_o + 4.
REQ-020 SHALL have port count_o, output, $clog2(DEPTH)+1, meaning occupied entries.

Function
REQ-021 SHALL hold a fetch PC register and a circular FIFO of {instr, pc} with read/write pointers wrapping modulo DEPTH.
REQ-022 SHALL assert fetch_req_o when not flushing, hold_i low, and (count < DEPTH or a pop occurs this cycle).
REQ-023 SHALL, on fetch_req_o && fetch_ready_i, push {fetch_data_i, fetch_addr_o} and advance the fetch PC by 4 (wraps modulo 2^ADDR_W).
REQ-024 SHALL pop the head on instr_valid_o && instr_ready_i; push and pop in one cycle leave count unchanged.
REQ-025 SHALL drive instr_valid_o = (count != 0); instr_o/pc_o hold the head entry while valid and not popped.
REQ-026 SHALL, on jump_flag_i, clear the FIFO (count 0), deassert fetch_req_o and instr_valid_o that cycle, discard any fetch response, and load fetch PC with {jump_addr_i[ADDR_W-1:2], 2'b00}.
REQ-027 SHALL treat jtag_reset_flag_i like jump_flag_i with target RESET_PC; jtag_reset_flag_i has priority when both assert.
REQ-028 SHALL issue the first post-redirect request in the cycle after the redirect.
REQ-029 SHALL never overflow: no push when count == DEPTH and no pop; never underflow: no pop when empty.
REQ-030 SHALL leave fetch PC and FIFO unchanged while hold_i is high, except for pops and redirects.

Reset
REQ-031 SHALL, while rst_i is high, force fetch PC = RESET_PC, pointers = 0, count_o = 0, instr_valid_o = 0, fetch_req_o = 0, instr_o = 0, pc_o = 0, pc_next_o = 0.
REQ-032 SHALL begin fetching at RESET_PC in the first cycle after rst_i deasserts; reset asserted mid-transfer drops the in-flight response.

Configuration
REQ-033 SHALL, with macro PREFETCH_BYPASS_EN defined, forward a fetch response straight to instr_o/pc_o with instr_valid_o high in the same cycle when the FIFO is empty; if also consumed, it is not written to the FIFO.
REQ-034 SHALL, without PREFETCH_BYPASS_EN, present every instruction only from the FIFO, giving a one-cycle minimum fetch-to-valid latency.

Verification
REQ-035 Reset release, fetch_ready_i=1, instr_ready_i=1 -> addresses 0x0,0x4,0x8 in consecutive cycles; pc_o sequence 0x0,0x4,0x8; pc_next_o = pc_o+4.
REQ-036 DEPTH=4, instr_ready_i=0, fetch_ready_i=1 -> exactly 4 pushes, count_o=4, fetch_req_o low; one pop -> one further fetch at 0x10.
REQ-037 count_o=3, jump_flag_i=1 with jump_addr_i=0x0000_0103 -> next cycle count_o=0, fetch_addr_o=0x0000_0100; no stale instruction presented.
REQ-038 jump_flag_i=1 (0x200) and jtag_reset_flag_i=1 in the same cycle -> next fetch_addr_o=RESET_PC.
REQ-039 Empty FIFO, response 0x0000_0013 at pc 0x40 -> PREFETCH_BYPASS_EN: instr_valid_o high same cycle; undefined: high one cycle later.
REQ-040 fetch_addr_o=0xFFFF_FFFC accepted -> next fetch_addr_o=0x0000_0000.

Source files
------------

// File: rtl/instr_prefetch_buf.sv
`default_nettype none
// instr_prefetch_buf: instruction prefetch FIFO with redirect flush. Rev 1.0
// Define PREFETCH_BYPASS_EN to forward a response straight to decode when the FIFO is empty.
module instr_prefetch_buf #(
  parameter int                DEPTH    = 4,
  parameter int                ADDR_W   = 32,
  parameter int                INSTR_W  = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  output logic                       fetch_req_o,
  output logic [ADDR_W-1:0]          fetch_addr_o,
  input  logic                       fetch_ready_i,
  input  logic [INSTR_W-1:0]         fetch_data_i,
  input  logic                       jump_flag_i,
  input  logic [ADDR_W-1:0]          jump_addr_i,
  input  logic                       jtag_reset_flag_i,
  input  logic                       hold_i,
  output logic                       instr_valid_o,
  input  logic                       instr_ready_i,
  output logic [INSTR_W-1:0]         instr_o,
  output logic [ADDR_W-1:0]          pc_o,
  output logic [ADDR_W-1:0]          pc_next_o,
  output logic [$clog2(DEPTH):0]     count_o
);

  localparam int                PTR_W     = $clog2(DEPTH);
  localparam int                CNT_W     = PTR_W + 1;
  localparam logic [CNT_W-1:0]  DEPTH_CNT = CNT_W'(DEPTH);
  localparam logic [ADDR_W-1:0] RESET_AL  = {RESET_PC[ADDR_W-1:2], 2'b00};

  logic [ADDR_W-1:0]  fetch_pc;
  logic [INSTR_W-1:0] instr_mem [DEPTH];
  logic [ADDR_W-1:0]  pc_mem    [DEPTH];
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic [CNT_W-1:0]   count;

  logic              flush;
  logic [ADDR_W-1:0] redirect_pc;
  logic              fifo_valid;
  logic              pop_fifo;
  logic              accept;
  logic              bypass_valid;
  logic              bypass_take;
  logic              push_fifo;
  logic              unused_addr_bits;

  assign unused_addr_bits = ^jump_addr_i[1:0];

  always_comb begin
    flush       = jump_flag_i | jtag_reset_flag_i;
    redirect_pc = jtag_reset_flag_i ? RESET_AL : {jump_addr_i[ADDR_W-1:2], 2'b00};
    fifo_valid  = (count != '0) && !flush;
    pop_fifo    = fifo_valid && instr_ready_i;
    // A pop frees a slot this cycle, so a full FIFO can still refill back-to-back.
    fetch_req_o = !rst_i && !flush && !hold_i && ((count < DEPTH_CNT) || pop_fifo);
    accept      = fetch_req_o && fetch_ready_i;
`ifdef PREFETCH_BYPASS_EN
    bypass_valid = (count == '0) && accept;
`else
    bypass_valid = 1'b0;
`endif
    bypass_take   = bypass_valid && instr_ready_i;
    push_fifo     = accept && !bypass_take;
    instr_valid_o = fifo_valid || bypass_valid;
    instr_o       = '0;
    pc_o          = '0;
    if (fifo_valid) begin
      instr_o = instr_mem[rd_ptr];
      pc_o    = pc_mem[rd_ptr];
    end else if (bypass_valid) begin
      instr_o = fetch_data_i;
      pc_o    = fetch_pc;
    end
    pc_next_o    = instr_valid_o ? pc_o + ADDR_W'(4) : '0;
    fetch_addr_o = fetch_pc;
    count_o      = count;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      fetch_pc <= RESET_AL;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
    end else if (flush) begin
      fetch_pc <= redirect_pc;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
    end else begin
      if (accept)    fetch_pc <= fetch_pc + ADDR_W'(4);
      if (push_fifo) wr_ptr   <= wr_ptr + PTR_W'(1);
      if (pop_fifo)  rd_ptr   <= rd_ptr + PTR_W'(1);
      count <= count + CNT_W'(push_fifo) - CNT_W'(pop_fifo);
    end
  end

  // Storage needs no reset: entries are only read while count says they are live.
  always_ff @(posedge clk_i) begin
    if (push_fifo) begin
      instr_mem[wr_ptr] <= fetch_data_i;
      pc_mem[wr_ptr]    <= fetch_pc;
    end
  end

endmodule
`default_nettype wire
